// File: rtl/chaotic_iter_scheduler.sv
// rtl/chaotic_iter_scheduler.sv - round-robin step sequencer for the shared chaotic iteration engine
//
// Issues one engine step at a time over the enabled systems in ascending
// index order, waits for the matching completion, counts completed rounds
// and ends the run on a round target, a stop request or an engine timeout.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, stop            run control pulses
//   iter_target            rounds to run (0 = run until stop)
//   sys_mask               enabled systems, sampled at start
//   eng_ready              engine accepts a step
//   eng_start/eng_sys/eng_init  step request, system index, use-initial-value flag
//   eng_done/eng_done_sys  engine completion and its system index
//   busy, done             run in progress, one-cycle end-of-run pulse
//   round_cnt              completed rounds of current/last run
//   err_seq, err_timeout   sticky error flags, cleared at start
module chaotic_iter_scheduler #(
    parameter int NUM_SYS = 6,
    parameter int IDX_W   = 8,
    parameter int ITER_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ITER_W-1:0] iter_target,
    input  logic [NUM_SYS-1:0] sys_mask,
    input  logic              eng_ready,
    output logic              eng_start,
    output logic [IDX_W-1:0]  eng_sys,
    output logic              eng_init,
    input  logic              eng_done,
    input  logic [IDX_W-1:0]  eng_done_sys,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] round_cnt,
    output logic              err_seq,
    output logic              err_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t              state_q;
    logic [NUM_SYS-1:0]  mask_q;
    logic [ITER_W-1:0]   target_q;
    logic [IDX_W-1:0]    cur_q;
    logic [ITER_W-1:0]   round_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                stop_pend_q;
    logic                busy_q;
    logic                done_q;
    logic                eng_start_q;
    logic [IDX_W-1:0]    eng_sys_q;
    logic                eng_init_q;
    logic                err_seq_q;
    logic                err_to_q;

    logic [IDX_W-1:0]    start_low_d;
    logic [IDX_W-1:0]    nxt_sys_d;
    logic                nxt_found_d;
    logic [ITER_W-1:0]   round_nxt_d;
    logic                stop_now_d;
    logic                hit_target_d;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SYS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_SYS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    // Next enabled system above cur; falling off the top wraps to the lowest
    // enabled system and closes a round.
    always_comb begin
        start_low_d = lowest_set(sys_mask);
        nxt_found_d = 1'b0;
        nxt_sys_d   = lowest_set(mask_q);
        for (int i = NUM_SYS - 1; i >= 0; i--) begin
            if (mask_q[i] && (IDX_W'(i) > cur_q)) begin
                nxt_found_d = 1'b1;
                nxt_sys_d   = IDX_W'(i);
            end
        end
        round_nxt_d  = nxt_found_d ? round_q : round_q + 1'b1;
        stop_now_d   = stop_pend_q | stop;
        hit_target_d = (target_q != '0) && (round_nxt_d == target_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            target_q    <= '0;
            cur_q       <= '0;
            round_q     <= '0;
            wait_q      <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_sys_q   <= '0;
            eng_init_q  <= 1'b0;
            err_seq_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A completion the scheduler is not waiting for is flagged and dropped.
            if (eng_done && (state_q != S_WAIT)) err_seq_q <= 1'b1;
            if (stop && (state_q != S_IDLE)) stop_pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q      <= sys_mask;
                        target_q    <= iter_target;
                        round_q     <= '0;
                        err_seq_q   <= 1'b0;
                        err_to_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        stop_pend_q <= stop;
                        if (sys_mask == '0) begin
                            state_q <= S_FINISH;
                        end else begin
                            cur_q       <= start_low_d;
                            eng_start_q <= 1'b1;
                            eng_sys_q   <= start_low_d;
                            eng_init_q  <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (eng_ready) begin
                        eng_start_q <= 1'b0;
                        wait_q      <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_done) begin
                        if (eng_done_sys != cur_q) err_seq_q <= 1'b1;
                        state_q <= S_ADVANCE;
                    end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                        err_to_q <= 1'b1;
                        state_q  <= S_FINISH;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    cur_q   <= nxt_sys_d;
                    round_q <= round_nxt_d;
                    if (stop_now_d || hit_target_d) begin
                        state_q <= S_FINISH;
                    end else begin
                        eng_start_q <= 1'b1;
                        eng_sys_q   <= nxt_sys_d;
                        eng_init_q  <= (round_nxt_d == '0);
                        state_q     <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    stop_pend_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_sys     = eng_sys_q;
    assign eng_init    = eng_init_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign round_cnt   = round_q;
    assign err_seq     = err_seq_q;
    assign err_timeout = err_to_q;

endmodule
